// File: rtl/sdram_test_sequencer.sv
// Drives the SDRAM controller through a full write pass, then a read/compare pass, over 0..LAST_ADDR.
// Requests are launched one cycle after entering a request state; status outputs lag the state by one cycle.
module sdram_test_sequencer #(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 32,
    parameter int LAST_ADDR = 2**ADDR_W - 1,
    parameter int INIT_WAIT = 20000
) (
    input  logic              refclk,
    input  logic              reset_n,
    input  logic              sw,
    input  logic              init_done,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              ack,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              init,
    output logic              write,
    output logic              read,
    output logic              stop_led,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int CNT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INIT_WAIT - 1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_INIT, S_WR_REQ, S_RD_REQ, S_RD_DATA, S_DONE, S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d, inv_q, inv_d;
    logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sw_meta_q, sw_sync_q, sw_prev_q;
    logic              init_q, write_q, read_q, stop_q, error_q;
    logic              restart, at_last, rd_match, rd_check;
    logic [ADDR_W-1:0] addr_inc;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic flip);
        return DATA_W'(a) ^ {DATA_W{flip}};
    endfunction

    // Pushbutton idles high; restart fires on the synchronized falling edge only.
    assign restart  = sw_prev_q & ~sw_sync_q;
    assign at_last  = (addr_q == LAST);
    assign addr_inc = addr_q + 1'b1;
    assign rd_match = (rdata == pattern(addr_q, inv_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        inv_d      = inv_q;
        err_addr_d = err_addr_q;
        rd_check   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (init_done || cnt_q != '0) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        addr_d  = '0;
                        state_d = S_WR_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = pattern(addr_q, inv_q);
                end else if (ack) begin
                    if (at_last) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = '0;
                        state_d = S_RD_REQ;
                    end else begin
                        addr_d  = addr_inc;
                        wdata_d = pattern(addr_inc, inv_q);
                    end
                end
            end
            S_RD_REQ: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    we_d  = 1'b0;
                end else if (ack) begin
                    req_d = 1'b0;
                    if (rvalid) begin
                        rd_check = 1'b1;
                    end else begin
                        state_d = S_RD_DATA;
                    end
                end
            end
            S_RD_DATA: rd_check = rvalid;
            S_DONE, S_FAIL: begin
                if (restart) begin
                    inv_d   = ~inv_q;
                    addr_d  = '0;
                    state_d = S_WR_REQ;
                end
            end
            default: state_d = S_INIT;
        endcase

        if (rd_check) begin
            if (!rd_match) begin
                err_addr_d = addr_q;
                state_d    = S_FAIL;
            end else if (at_last) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_inc;
                state_d = S_RD_REQ;
            end
        end
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            inv_q      <= 1'b0;
            err_addr_q <= '0;
            sw_meta_q  <= 1'b1;
            sw_sync_q  <= 1'b1;
            sw_prev_q  <= 1'b1;
            init_q     <= 1'b1;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            stop_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            inv_q      <= inv_d;
            err_addr_q <= err_addr_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            sw_prev_q  <= sw_sync_q;
            init_q     <= (state_q == S_INIT);
            write_q    <= (state_q == S_WR_REQ);
            read_q     <= (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
            stop_q     <= (state_q == S_DONE) || (state_q == S_FAIL);
            error_q    <= (state_q == S_FAIL);
        end
    end

    assign req      = req_q;
    assign we       = we_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign init     = init_q;
    assign write    = write_q;
    assign read     = read_q;
    assign stop_led = stop_q;
    assign error    = error_q;
    assign err_addr = err_addr_q;
endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Bench for sdram_test_sequencer: behavioural SDRAM port model with a write/read scoreboard.
module tb_sdram_test_sequencer;
    localparam int ADDR_W = 21, DATA_W = 32, LAST_ADDR = 15, INIT_WAIT = 8, TMO = 3000;

    logic              refclk = 1'b0;
    logic              reset_n, sw, init_done, req, we, ack, rvalid;
    logic              init, write, read, stop_led, error;
    logic [ADDR_W-1:0] addr, err_addr;
    logic [DATA_W-1:0] wdata, rdata;

    int n_cmp = 0, n_fail = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    logic [DATA_W-1:0] mem [16];
    bit                exp_inv, stall_en, rand_lat, corrupt_en;
    logic [ADDR_W-1:0] corrupt_addr;
    int                hold_checks, hold_viol;

    // model state
    bit                rd_pend, p_req, p_ack, p_we;
    int                rd_delay, stall_left, lat;
    logic [DATA_W-1:0] rd_val, p_wdata;
    logic [ADDR_W-1:0] p_addr, e_rd;
    wr_t               e_wr;

    sdram_test_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST_ADDR), .INIT_WAIT(INIT_WAIT)
    ) dut (
        .refclk(refclk), .reset_n(reset_n), .sw(sw), .init_done(init_done),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rvalid(rvalid), .rdata(rdata),
        .init(init), .write(write), .read(read), .stop_led(stop_led),
        .error(error), .err_addr(err_addr)
    );

    always #5 refclk = ~refclk;

    function automatic logic [DATA_W-1:0] pat(input int a, input bit inv);
        return DATA_W'(a) ^ {DATA_W{inv}};
    endfunction

    // SDRAM port model: acks at the falling edge, returns read data after a latency,
    // and scores every accepted transaction against the expectation queues.
    initial begin : sdram_model
        ack = 0; rvalid = 0; rdata = '0;
        rd_pend = 0; p_req = 0; p_ack = 0; p_we = 0; stall_left = 0;
        p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge refclk);
            ack = 0;
            rvalid = 0;
            if (!reset_n) begin
                rd_pend = 0;
                stall_left = 0;
            end else begin
                if (p_req && !p_ack && req) begin
                    hold_checks++;
                    if (addr !== p_addr || we !== p_we || (we && wdata !== p_wdata)) hold_viol++;
                end
                if (rd_pend) begin
                    if (rd_delay <= 1) begin
                        rvalid = 1; rdata = rd_val; rd_pend = 0;
                    end else begin
                        rd_delay--;
                    end
                end
                if (req && !rd_pend) begin
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        ack = 1;
                        n_cmp++;
                        if (we) begin
                            mem[addr[3:0]] = wdata;
                            if (exp_wr.size() == 0) begin
                                n_fail++;
                                $display("FAIL wr_unexpected: got addr %0d data %h, required no write", addr, wdata);
                            end else begin
                                e_wr = exp_wr.pop_front();
                                if (addr !== e_wr.a || wdata !== e_wr.d) begin
                                    n_fail++;
                                    $display("FAIL wr_txn: got addr %0d data %h, required addr %0d data %h",
                                             addr, wdata, e_wr.a, e_wr.d);
                                end
                            end
                        end else begin
                            if (exp_rd.size() == 0) begin
                                n_fail++;
                                $display("FAIL rd_unexpected: got read addr %0d, required no read", addr);
                            end else begin
                                e_rd = exp_rd.pop_front();
                                if (addr !== e_rd) begin
                                    n_fail++;
                                    $display("FAIL rd_txn: got addr %0d, required addr %0d", addr, e_rd);
                                end
                            end
                            rd_val = mem[addr[3:0]] ^ ((corrupt_en && addr == corrupt_addr) ? 32'd1 : 32'd0);
                            lat = rand_lat ? int'($urandom_range(3, 0)) : 3;
                            if (lat == 0) begin
                                rvalid = 1; rdata = rd_val;
                            end else begin
                                rd_pend = 1; rd_delay = lat;
                            end
                        end
                        stall_left = stall_en ? int'($urandom_range(5, 0)) : 0;
                    end
                end
            end
            p_req = req; p_ack = ack; p_we = we; p_addr = addr; p_wdata = wdata;
        end
    end

    task automatic push_pass(input int n_reads);
        for (int a = 0; a <= LAST_ADDR; a++) exp_wr.push_back('{a: ADDR_W'(a), d: pat(a, exp_inv)});
        for (int a = 0; a < n_reads; a++) exp_rd.push_back(ADDR_W'(a));
    endtask

    task automatic pulse_sw();
        @(negedge refclk); sw = 0;
        @(negedge refclk); sw = 1;
    endtask

    // 0: write, 1: stop_led, 2: read, 3: read request at addr 7, 4: write request at addr 5
    task automatic wait_sig(input int which, input int max_cyc, output bit ok, output int cyc);
        ok = 0; cyc = 0;
        while (!ok && cyc < max_cyc) begin
            @(negedge refclk); #1; cyc++;
            case (which)
                0:       ok = (write === 1'b1);
                1:       ok = (stop_led === 1'b1);
                2:       ok = (read === 1'b1);
                3:       ok = (req === 1'b1 && we === 1'b0 && read === 1'b1 && addr == 7);
                default: ok = (req === 1'b1 && we === 1'b1 && addr == 5);
            endcase
        end
    endtask

    task automatic test_reset();
        reset_n = 0; sw = 1; init_done = 0;
        stall_en = 0; rand_lat = 0; corrupt_en = 0; corrupt_addr = '0; exp_inv = 0;
        hold_checks = 0; hold_viol = 0;
        repeat (3) @(negedge refclk); #1;
        n_cmp++;
        if ({init, req, we, write, read, stop_led, error} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_status: got init/req/we/wr/rd/stop/err %b, required 1000000",
                     {init, req, we, write, read, stop_led, error});
        end
        n_cmp++;
        if (addr !== '0 || wdata !== '0 || err_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got addr %0d wdata %h err_addr %0d, required 0 0 0", addr, wdata, err_addr);
        end
        @(negedge refclk); reset_n = 1;
    endtask

    task automatic test_init_write();
        bit ok; int cyc;
        repeat (19) @(negedge refclk);
        push_pass(LAST_ADDR + 1);
        init_done = 1;
        repeat (INIT_WAIT) @(negedge refclk); #1;
        n_cmp++;
        if (init !== 1'b1 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL init_hold: got init %b write %b, required 1 0", init, write);
        end
        @(negedge refclk); #1;
        n_cmp++;
        if ({init, write, req, we} !== 4'b0111 || addr !== '0) begin
            n_fail++;
            $display("FAIL init_exit: got init/write/req/we %b addr %0d, required 0111 addr 0",
                     {init, write, req, we}, addr);
        end
        wait_sig(2, TMO, ok, cyc);
        n_cmp++;
        if (!ok || exp_wr.size() != 0 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL write_pass: got read %b, %0d writes missing, required read 1 and 0 missing", read, exp_wr.size());
        end
    endtask

    task automatic test_read_pass(input string name);
        bit ok; int cyc;
        wait_sig(1, TMO, ok, cyc);
        n_cmp++;
        if (!ok || {stop_led, error, read, write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s_done: got stop/err/read/write %b, required 1000", name, {stop_led, error, read, write});
        end
        n_cmp++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL %s_txns: got %0d writes %0d reads outstanding, required 0 0", name, exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic test_restart_pulse();
        bit ok; int cyc;
        exp_inv = 1;
        push_pass(LAST_ADDR + 1);
        pulse_sw();
        wait_sig(0, 8, ok, cyc);
        n_cmp++;
        if (!ok || cyc > 3) begin
            n_fail++;
            $display("FAIL restart_latency: got write %b after %0d cycles, required 1 within 3", write, cyc);
        end
        test_read_pass("restart");
    endtask

    task automatic test_sw_held();
        bit ok; int cyc;
        exp_inv = 0;
        push_pass(LAST_ADDR + 1);
        @(negedge refclk); sw = 0;
        wait_sig(0, 8, ok, cyc);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL held_restart: got write %b, required 1", write);
        end
        test_read_pass("held");
        repeat (12) @(negedge refclk); #1;
        n_cmp++;
        if (stop_led !== 1'b1 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL held_single: got stop %b write %b, required 1 0", stop_led, write);
        end
        sw = 1;
    endtask

    task automatic test_sw_during_write();
        bit ok; int cyc;
        exp_inv = 1;
        push_pass(LAST_ADDR + 1);
        pulse_sw();
        wait_sig(4, 40, ok, cyc);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midwrite_reach: got addr %0d req %b, required write request at addr 5", addr, req);
        end
        pulse_sw();
        test_read_pass("midwrite");
        repeat (8) @(negedge refclk); #1;
        n_cmp++;
        if (stop_led !== 1'b1) begin
            n_fail++;
            $display("FAIL midwrite_stay: got stop %b, required 1", stop_led);
        end
    endtask

    task automatic test_fail();
        bit ok; int cyc;
        exp_inv = 0; corrupt_en = 1; corrupt_addr = 9;
        push_pass(10);
        pulse_sw();
        wait_sig(0, 8, ok, cyc);
        wait_sig(1, TMO, ok, cyc);
        n_cmp++;
        if (!ok || {stop_led, error, read} !== 3'b110 || err_addr !== 21'd9) begin
            n_fail++;
            $display("FAIL fail_status: got stop/err/read %b err_addr %0d, required 110 err_addr 9",
                     {stop_led, error, read}, err_addr);
        end
        repeat (10) @(negedge refclk); #1;
        n_cmp++;
        if (req !== 1'b0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL fail_quiet: got req %b, %0d reads %0d writes outstanding, required 0 0 0",
                     req, exp_rd.size(), exp_wr.size());
        end
        corrupt_en = 0;
    endtask

    task automatic test_ack_stall();
        bit ok; int cyc;
        exp_inv = 1; stall_en = 1; rand_lat = 1; hold_checks = 0; hold_viol = 0;
        push_pass(LAST_ADDR + 1);
        pulse_sw();
        wait_sig(0, 8, ok, cyc);
        test_read_pass("stall");
        n_cmp++;
        if (hold_viol != 0 || hold_checks == 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d violations over %0d stalled cycles, required 0 over >0", hold_viol, hold_checks);
        end
        stall_en = 0; rand_lat = 0;
    endtask

    task automatic test_reset_mid_read();
        bit ok; int cyc;
        exp_inv = 0;
        push_pass(LAST_ADDR + 1);
        pulse_sw();
        wait_sig(3, TMO, ok, cyc);
        reset_n = 0; #1;
        n_cmp++;
        if (!ok || req !== 1'b0 || init !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_reset: got req %b init %b error %b, required 0 1 0", req, init, error);
        end
        exp_wr.delete(); exp_rd.delete();
        repeat (2) @(negedge refclk);
        reset_n = 1;
        push_pass(LAST_ADDR + 1);
        @(negedge refclk); #1;
        n_cmp++;
        if (init !== 1'b1 || err_addr !== '0) begin
            n_fail++;
            $display("FAIL midread_init: got init %b err_addr %0d, required 1 0", init, err_addr);
        end
        wait_sig(0, INIT_WAIT + 6, ok, cyc);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midread_rewrite: got write %b, required 1 after INIT", write);
        end
        test_read_pass("rerun");
    endtask

    initial begin
        test_reset();
        test_init_write();
        test_read_pass("pass1");
        test_restart_pulse();
        test_sw_held();
        test_sw_during_write();
        test_fail();
        test_ack_stall();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_test_sequencer.md
# sdram_test_sequencer

- Sequences the on-chip SDRAM controller through a full write pass and read/compare pass over a programmable address range.
- Reports the result on status outputs: init, write, read, stop_led, error.
- Sits between the pushbutton/LED top level and the SDRAM controller's request/acknowledge port.
- Runs on the PLL output clock, connected at top level to this block's `refclk` port.

## Interface
Parameters:
- ADDR_W, 21, SDRAM word address width
- DATA_W, 32, SDRAM data width
- LAST_ADDR, 2**ADDR_W-1, final address of each pass; reduced for simulation
- INIT_WAIT, 20000, cycles held in INIT after init_done before the first write

Ports:
- refclk  in  1  clock, PLL output clock
- reset_n  in  1  reset, asynchronous, active-low
- sw  in  1  restart pushbutton, active-low, asynchronous to refclk
- init_done  in  1  SDRAM controller power-up sequence complete
- req  out  1  transaction request to controller
- we  out  1  1 = write, 0 = read; valid while req=1
- addr  out  ADDR_W  transaction address
- wdata  out  DATA_W  write data
- ack  in  1  controller accepted current request
- rvalid  in  1  read data valid, one cycle
- rdata  in  DATA_W  read data
- init  out  1  high while in INIT
- write  out  1  high during write pass
- read  out  1  high during read pass
- stop_led  out  1  high in DONE or FAIL
- error  out  1  high in FAIL only
- err_addr  out  ADDR_W  address of first miscompare

## Operation
- States: INIT, WR_REQ, RD_REQ, RD_DATA, DONE, FAIL.
- INIT
  - Counter starts once init_done=1 and counts INIT_WAIT cycles.
  - Then: addr=0, go to WR_REQ.
  - init_done is ignored once INIT is left.
- Pattern:
  - pattern(a) = zero-extended a, XOR all-ones when inv=1.
  - inv resets to 0 and toggles on every restart.
- WR_REQ
  - req=1, we=1, wdata=pattern(addr).
  - On ack: if addr==LAST_ADDR, set addr=0 and go to RD_REQ; else addr+1.
- RD_REQ
  - req=1, we=0.
  - On ack: go to RD_DATA.
- RD_DATA
  - req=0. Wait for rvalid, then compare rdata with pattern(addr).
  - Mismatch: err_addr=addr, go to FAIL.
  - Match and addr==LAST_ADDR: go to DONE.
  - Match otherwise: addr+1, go to RD_REQ.
- Restart (sw)
  - sw passes through a 2-flop synchronizer; a falling edge of the synchronized signal is the restart event.
  - Accepted only in DONE or FAIL: clears error, toggles inv, addr=0, goes to WR_REQ. INIT is not repeated.
  - Ignored in all other states.
- Handshake: req, we, addr and wdata stay stable from req rise until the cycle ack=1 is sampled. ack while req=0 is ignored.
- Addresses never exceed LAST_ADDR; addr returns to 0 only as stated above, never by natural wrap.

## Timing
- Reset values:
  - state=INIT, init=1.
  - req=0, we=0, addr=0, wdata=0.
  - write=0, read=0, stop_led=0, error=0, err_addr=0, inv=0.
- Status outputs are registered decodes of state, valid the cycle after the state changes.
  - write=1 in WR_REQ.
  - read=1 in RD_REQ and RD_DATA.
  - stop_led=1 in DONE and FAIL.
- Request launch and ack:
  - req rises the cycle after entering WR_REQ or RD_REQ.
  - The next write request is presented the cycle after ack (back-to-back; req may stay high with new addr).
- Reads are strictly serial: one request, then one rvalid.
  - rvalid in the same cycle as ack in RD_REQ is captured and compared immediately (no RD_DATA dwell).
  - rvalid outside RD_REQ/RD_DATA is ignored.
- Restart event:
  - Sits 2–3 cycles after sw falls.
  - A 1-cycle-low sw pulse is detected; a held-low sw produces one restart only.
- Async reset:
  - Asserting reset_n mid-pass drops req immediately, returns to INIT and clears error/err_addr.
  - A pending ack after reset is ignored.

## Test plan
- Reset, INIT_WAIT=8, LAST_ADDR=15, init_done rising at cycle 20, zero-latency ack model:
  - init=1 until 8 cycles after init_done.
  - Then 16 writes, addr 0..15, wdata=addr.
- Error-free memory model with 3-cycle read latency, same parameters:
  - 16 reads compared.
  - stop_led=1, error=0, read=0 after addr 15 returns.
- Model corrupts rdata bit 0 at addr 9:
  - FAIL, error=1, err_addr=9, no request issued after addr 9.
- In DONE, 1-cycle low pulse on sw:
  - Restart within 3 cycles, write=1, wdata at addr 0 = all-ones (inv=1).
  - A second full pass passes.
- sw pulsed during the write pass at addr 5:
  - Ignored; pass completes normally.
- reset_n asserted while req=1 at addr 7 of the read pass:
  - req=0 same cycle, init=1, error=0.
  - Sequence restarts from INIT.
- Random ack stalls of 0–5 cycles:
  - addr, we and wdata unchanged while req=1 and ack=0 (assertion check).
